// File: rtl/alu_exec_unit.sv
// Execution unit for the ALU control encoding: single-cycle logic/arith/compare
// ops plus an iterative shift-add multiplier, with a registered result and zero flag.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [2:0]       bonus_control_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_CMP = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] alu_res;
    logic [CNT_W-1:0] cnt;
    logic             alu_err;
    logic             is_mul;
    logic             mul_last;

    assign is_mul   = (ALUCtrl_i == OP_MUL);
    assign mul_last = (cnt == CNT_W'(WIDTH - 1));
    assign acc_nxt  = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_i && is_mul) state_nxt = S_MUL;
            S_MUL:   if (mul_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state == S_MUL);
    end

    // Compare variants outside the four defined encodings fall back to slt.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (ALUCtrl_i)
            OP_AND: alu_res = src1_i & src2_i;
            OP_OR:  alu_res = src1_i | src2_i;
            OP_ADD: alu_res = src1_i + src2_i;
            OP_SUB: alu_res = src1_i - src2_i;
            OP_CMP: begin
                case (bonus_control_i)
                    3'b001:  alu_res[0] = ($signed(src1_i) >  $signed(src2_i));
                    3'b100:  alu_res[0] = (src1_i != src2_i);
                    3'b101:  alu_res[0] = ($signed(src1_i) >= $signed(src2_i));
                    default: alu_res[0] = ($signed(src1_i) <  $signed(src2_i));
                endcase
            end
            OP_MUL: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result_o <= '0;
            zero_o   <= 1'b1;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        if (is_mul) begin
                            acc    <= '0;
                            mcand  <= src1_i;
                            mplier <= src2_i;
                            cnt    <= '0;
                        end else begin
                            result_o <= alu_res;
                            zero_o   <= (alu_res == '0);
                            done_o   <= 1'b1;
                            err_o    <= alu_err;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    // Final step publishes the accumulator including this step's add.
                    if (mul_last) begin
                        result_o <= acc_nxt;
                        zero_o   <= (acc_nxt == '0);
                        done_o   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_alu_exec_unit;

    localparam int unsigned W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [3:0]   ALUCtrl_i;
    logic [2:0]   bonus_control_i;
    logic [W-1:0] src1_i;
    logic [W-1:0] src2_i;
    logic [W-1:0] result_o;
    logic         zero_o;
    logic         busy_o;
    logic         done_o;
    logic         err_o;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .ALUCtrl_i       (ALUCtrl_i),
        .bonus_control_i (bonus_control_i),
        .src1_i          (src1_i),
        .src2_i          (src2_i),
        .result_o        (result_o),
        .zero_o          (zero_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         err;
        int unsigned  due;
    } exp_t;

    exp_t        q[$];
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc   = 0;
    logic        mon_en = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic on the operation's definition.
    function automatic exp_t model(input logic [3:0] c, input logic [2:0] b,
                                   input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        longint      sx;
        longint      sy;
        logic [63:0] prod;
        sx    = longint'($signed(x));
        sy    = longint'($signed(y));
        e.res = '0;
        e.err = 1'b0;
        e.due = cyc + 1;
        case (c)
            4'd0: e.res = x & y;
            4'd1: e.res = x | y;
            4'd2: e.res = x + y;
            4'd6: e.res = x - y;
            4'd7: begin
                if (b == 3'b001)      e.res = (sx > sy)  ? 1 : 0;
                else if (b == 3'b100) e.res = (sx != sy) ? 1 : 0;
                else if (b == 3'b101) e.res = (sx >= sy) ? 1 : 0;
                else                  e.res = (sx < sy)  ? 1 : 0;
            end
            4'd8: begin
                prod  = {32'd0, x} * {32'd0, y};
                e.res = prod[W-1:0];
                e.due = cyc + W + 1;
            end
            default: e.err = 1'b1;
        endcase
        e.zero = (e.res == 0);
        return e;
    endfunction

    // Drive an op at the current falling edge once the unit is idle; start_i stays
    // high so consecutive calls issue back-to-back.
    task automatic issue(input logic [3:0] c, input logic [2:0] b,
                         input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned guard = 0;
        while (busy_o === 1'b1 && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 200) begin
            tests++;
            fails++;
            $display("FAIL busy_timeout: busy_o still %b after %0d cycles, required 0", busy_o, guard);
        end
        start_i         = 1'b1;
        ALUCtrl_i       = c;
        bonus_control_i = b;
        src1_i          = x;
        src2_i          = y;
        q.push_back(model(c, b, x, y));
        @(negedge clk_i);
    endtask

    task automatic idle(input int unsigned n);
        start_i = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            ALUCtrl_i = 4'($urandom);
            src1_i    = $urandom;
            src2_i    = $urandom;
            @(negedge clk_i);
        end
    endtask

    always @(negedge clk_i) begin
        if (mon_en && rst_i) begin
            if (done_o) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_done: done_o=1 result_o=0x%08h with no op outstanding, required done_o=0", result_o);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("result", result_o, e.res);
                    check("zero", W'(zero_o), W'(e.zero));
                    check("err", W'(err_o), W'(e.err));
                    check("latency_cycle", W'(cyc), W'(e.due));
                end
            end else begin
                if (err_o) begin
                    tests++;
                    fails++;
                    $display("FAIL err_without_done: err_o=1 done_o=0, required err_o=0");
                end
                if (q.size() > 0 && cyc > q[0].due) begin
                    tests++;
                    fails++;
                    $display("FAIL late_done: no done_o by cycle %0d, required at cycle %0d", cyc, q[0].due);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [3:0]   c;
        logic [W-1:0] held;
        int unsigned  guard;
        logic [3:0]   legal [7] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd15};

        rst_i = 1'b0;
        start_i = 1'b0;
        ALUCtrl_i = '0;
        bonus_control_i = '0;
        src1_i = '0;
        src2_i = '0;
        repeat (3) @(negedge clk_i);
        check("reset_result", result_o, '0);
        check("reset_zero", W'(zero_o), W'(1));
        check("reset_busy", W'(busy_o), W'(0));
        check("reset_done", W'(done_o), W'(0));
        check("reset_err", W'(err_o), W'(0));
        rst_i = 1'b1;
        mon_en = 1'b1;
        @(negedge clk_i);

        issue(4'd2, 3'd0, 32'h7FFF_FFFF, 32'd1);
        issue(4'd6, 3'd0, 32'd5, 32'd5);
        idle(2);

        issue(4'd7, 3'b000, 32'hFFFF_FFFF, 32'd1);
        issue(4'd7, 3'b001, 32'hFFFF_FFFF, 32'd1);
        issue(4'd7, 3'b100, 32'hFFFF_FFFF, 32'd1);
        issue(4'd7, 3'b101, 32'hFFFF_FFFF, 32'd1);
        issue(4'd7, 3'b111, 32'hFFFF_FFFF, 32'd1);
        idle(2);

        held = result_o;
        issue(4'd8, 3'd0, 32'h0000_FFFF, 32'h0001_0001);
        start_i = 1'b1;
        ALUCtrl_i = 4'd2;
        src1_i = 32'd100;
        src2_i = 32'd23;
        @(negedge clk_i);
        idle(3);
        check("mul_ignored_start_result", result_o, held);
        check("mul_busy", W'(busy_o), W'(1));
        issue(4'd8, 3'd0, 32'h8000_0000, 32'd2);
        issue(4'd8, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(1);

        issue(4'd15, 3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        issue(4'd0, 3'd0, 32'h0000_F0F0, 32'h0000_FF00);
        idle(2);

        issue(4'd8, 3'd0, 32'h0000_1234, 32'h0000_5678);
        idle(9);
        #2;
        rst_i = 1'b0;
        #1;
        check("async_rst_result", result_o, '0);
        check("async_rst_zero", W'(zero_o), W'(1));
        check("async_rst_busy", W'(busy_o), W'(0));
        check("async_rst_done", W'(done_o), W'(0));
        q.delete();
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        @(negedge clk_i);
        idle(40);
        issue(4'd2, 3'd0, 32'd2, 32'd3);
        idle(2);

        for (int unsigned n = 0; n < 200; n++) begin
            c = legal[$urandom_range(6, 0)];
            if (c == 4'd15) begin
                c = 4'($urandom);
                while (c == 4'd0 || c == 4'd1 || c == 4'd2 || c == 4'd6 || c == 4'd7 || c == 4'd8)
                    c = 4'($urandom);
            end
            case ($urandom_range(3, 0))
                0:       issue(c, 3'($urandom), 32'h8000_0000 ^ 32'($urandom_range(1, 0)), $urandom);
                1:       issue(c, 3'($urandom), $urandom, $urandom & 32'h0000_00FF);
                default: issue(c, 3'($urandom), $urandom, $urandom);
            endcase
            if ($urandom_range(3, 0) == 0) idle($urandom_range(2, 1));
        end
        idle(1);

        guard = 0;
        while (q.size() > 0 && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d ops still outstanding, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the ALU control encoding: accepts one operation per handshake (ALUCtrl_i plus bonus_control_i) with two operands.
- Produces a registered result with zero flag. Single-cycle ops finish in 1 clock; MUL runs as an iterative shift-add over WIDTH clocks.
- Sits between the ALU controller / decode stage and writeback. Issue logic stalls on busy_o.

Parameters:
- WIDTH, 32, operand/result width in bits; the MUL iteration counter is clog2(WIDTH) bits.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous active-low reset.
- start_i  input  1  issue strobe; sampled only in IDLE.
- ALUCtrl_i  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 compare, 1000 MUL; all other codes illegal.
- bonus_control_i  input  3  compare variant for 0111: 000 slt, 001 sgt, 100 neq, 101 sge; any other value behaves as 000.
- src1_i  input  WIDTH  operand 1.
- src2_i  input  WIDTH  operand 2.
- result_o  output  WIDTH  registered result.
- zero_o  output  1  result_o == 0, registered together with result_o.
- busy_o  output  1  high while in MUL state.
- done_o  output  1  one-cycle pulse: result_o/zero_o updated this cycle.
- err_o  output  1  one-cycle pulse coincident with done_o when the issued code was illegal.

Behaviour:
- Reset (rst_i low, asynchronous):
  - result_o=0, zero_o=1, busy_o=0, done_o=0, err_o=0, state=IDLE.
  - MUL accumulator, multiplicand, multiplier and counter are cleared.
  - Reset during MUL aborts the operation; no done_o is produced.
- States: IDLE, MUL. busy_o = (state==MUL).
- IDLE with start_i=1 at a rising edge:
  - Non-MUL code: on that same edge, result_o/zero_o load and done_o=1 for the following cycle. Latency 1. State stays IDLE.
  - MUL (1000): on that edge, load multiplicand=src1_i, multiplier=src2_i, acc=0, cnt=0, state=MUL. No done_o.
- MUL state, each edge:
  - If multiplier[0]=1, acc += multiplicand.
  - multiplicand <<= 1; multiplier >>= 1; cnt++.
  - On the edge where cnt==WIDTH-1 before the increment: result_o = final acc (including this step), zero_o updates, done_o pulses, state returns to IDLE.
  - Total latency from the start edge to done_o high is WIDTH+1 edges.
- MUL output is the low WIDTH bits of the product; this is identical for signed and unsigned operands.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- Compare (0111) uses signed two's-complement comparison. Result is 1 if true, else 0:
  - slt: src1 < src2.
  - sgt: src1 > src2.
  - neq: src1 != src2.
  - sge: src1 >= src2.
- Illegal code: result_o=0, zero_o=1, done_o=1 and err_o=1 for one cycle; latency 1.
- Handshake and hold rules:
  - start_i while busy_o=1 is ignored; it is neither queued nor acted on.
  - start_i in the cycle done_o is high is accepted, since state is already IDLE. Back-to-back single-cycle ops give done_o high on consecutive cycles.
  - result_o and zero_o hold their value between done pulses.
  - Operand and control inputs are don't-care after the start edge. MUL never re-samples src1_i, src2_i, ALUCtrl_i or bonus_control_i.
  - done_o and err_o are 0 in every cycle other than the completion cycle.

Test Plan:
- Reset release, then ADD src1=0x7FFFFFFF, src2=1 -> next cycle done_o=1, result_o=0x80000000, zero_o=0. Then SUB 5-5 -> result_o=0, zero_o=1.
- Compare with src1=0xFFFFFFFF (-1), src2=1, bonus 000/001/100/101 issued back-to-back -> result_o 1, 0, 1, 0 on four consecutive done pulses. Repeat with bonus 111 -> 1.
- MUL 0x0000_FFFF * 0x0001_0001 -> busy_o high for 32 cycles, done_o on edge 33 after start, result_o=0xFFFF_FFFF. A start_i pulse mid-operation is ignored and result_o is unchanged until done.
- MUL 0x8000_0000 * 2 -> result_o=0, zero_o=1. Then MUL 0xFFFFFFFF * 0xFFFFFFFF -> result_o=1.
- Illegal ALUCtrl_i=1111 -> done_o=1, err_o=1, result_o=0 for one cycle. A following AND 0xF0F0 & 0xFF00 -> result_o=0xF000, err_o=0.
- Assert rst_i low asynchronously at MUL cycle 10 -> outputs go to reset values immediately and no done_o follows. After release, ADD 2+3 -> result_o=5 with latency 1.
